riscv_run_ctrl: RTL and testbench

//   Synthesizable run-control unit placed between the host/debug port and the

---
 rtl/riscv_run_ctrl.sv | 157 +++++++++++++++
 tb/tb_riscv_run_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_run_ctrl.sv
// Run-control unit between the host/debug port and the single-cycle RISC-V core:
// core clock-enable, held core reset, run/halt, N-step, PC breakpoints, cycle counter.
module riscv_run_ctrl #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned NUM_BP     = 2,
    parameter int unsigned RST_CYCLES = 4
) (
    input  logic                   clock,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_op,
    input  logic [CNT_W-1:0]       cmd_count,
    input  logic [NUM_BP-1:0]      bp_en,
    input  logic [NUM_BP*XLEN-1:0] bp_addr,
    input  logic [XLEN-1:0]        pc,
    output logic                   core_en,
    output logic                   core_rst_n,
    output logic                   halted,
    output logic [1:0]             halt_cause,
    output logic [31:0]            cycle_cnt
);

    localparam logic [1:0] OpHalt  = 2'd0;
    localparam logic [1:0] OpRun   = 2'd1;
    localparam logic [1:0] OpStep  = 2'd2;
    localparam logic [1:0] OpReset = 2'd3;

    localparam logic [1:0] CauseReset = 2'd0;
    localparam logic [1:0] CauseStep  = 2'd1;
    localparam logic [1:0] CauseHost  = 2'd2;
    localparam logic [1:0] CauseBreak = 2'd3;

    localparam int unsigned HoldW = $clog2(RST_CYCLES + 1);

    typedef enum logic [1:0] {StCoreRst, StHalted, StRun, StStep} state_e;

    state_e           state_q;
    logic [HoldW-1:0] hold_q;
    logic [CNT_W-1:0] steps_q;
    logic             skip_q;

    logic bp_hit;
    logic active;
    logic cmd_acc;
    logic stop_cmd;
    logic brk;

    always_comb begin
        bp_hit = 1'b0;
        for (int unsigned i = 0; i < NUM_BP; i++) begin
            if (bp_en[i] && (pc == bp_addr[i*XLEN +: XLEN])) begin
                bp_hit = 1'b1;
            end
        end
    end

    always_comb begin
        active    = (state_q == StRun) || (state_q == StStep);
        cmd_ready = (state_q != StCoreRst);
        cmd_acc   = cmd_valid && cmd_ready;
        stop_cmd  = cmd_acc && ((cmd_op == OpHalt) || (cmd_op == OpReset));
        // skip lets a resumed core execute the instruction it stopped on.
        brk       = bp_hit && !skip_q;
        core_en   = active && !brk && !stop_cmd;
    end

    always_ff @(posedge clock) begin
        if (!rst) begin
            state_q    <= StCoreRst;
            hold_q     <= HoldW'(RST_CYCLES);
            core_rst_n <= 1'b0;
            halted     <= 1'b0;
            halt_cause <= CauseReset;
            cycle_cnt  <= '0;
            steps_q    <= '0;
            skip_q     <= 1'b0;
        end else begin
            if (core_en) begin
                cycle_cnt <= cycle_cnt + 32'd1;
                skip_q    <= 1'b0;
            end
            unique case (state_q)
                StCoreRst: begin
                    cycle_cnt <= '0;
                    if (hold_q == HoldW'(1)) begin
                        state_q    <= StHalted;
                        core_rst_n <= 1'b1;
                        halted     <= 1'b1;
                        halt_cause <= CauseReset;
                    end else begin
                        hold_q <= hold_q - HoldW'(1);
                    end
                end
                StHalted: begin
                    if (cmd_acc) begin
                        case (cmd_op)
                            OpHalt: ;
                            OpRun: begin
                                state_q <= StRun;
                                halted  <= 1'b0;
                                skip_q  <= 1'b1;
                            end
                            OpStep: begin
                                if (cmd_count != '0) begin
                                    state_q <= StStep;
                                    steps_q <= cmd_count;
                                    halted  <= 1'b0;
                                    skip_q  <= 1'b1;
                                end
                            end
                            OpReset: begin
                                state_q    <= StCoreRst;
                                hold_q     <= HoldW'(RST_CYCLES);
                                core_rst_n <= 1'b0;
                                halted     <= 1'b0;
                                halt_cause <= CauseReset;
                                cycle_cnt  <= '0;
                                steps_q    <= '0;
                                skip_q     <= 1'b0;
                            end
                        endcase
                    end
                end
                StRun, StStep: begin
                    if (cmd_acc && (cmd_op == OpReset)) begin
                        state_q    <= StCoreRst;
                        hold_q     <= HoldW'(RST_CYCLES);
                        core_rst_n <= 1'b0;
                        halted     <= 1'b0;
                        halt_cause <= CauseReset;
                        cycle_cnt  <= '0;
                        steps_q    <= '0;
                        skip_q     <= 1'b0;
                    end else if (brk) begin
                        state_q    <= StHalted;
                        halted     <= 1'b1;
                        halt_cause <= CauseBreak;
                    end else if (cmd_acc && (cmd_op == OpHalt)) begin
                        state_q    <= StHalted;
                        halted     <= 1'b1;
                        halt_cause <= CauseHost;
                    end else if ((state_q == StStep) && core_en) begin
                        steps_q <= steps_q - CNT_W'(1);
                        if (steps_q == CNT_W'(1)) begin
                            state_q    <= StHalted;
                            halted     <= 1'b1;
                            halt_cause <= CauseStep;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_run_ctrl.sv
// Bench for riscv_run_ctrl: directed table, hand-written corner sequences and a
// randomized run against a per-cycle behavioural model.
module tb_riscv_run_ctrl;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned CNT_W      = 16;
    localparam int unsigned NUM_BP     = 2;
    localparam int unsigned RST_CYCLES = 4;

    logic                   clock = 1'b0;
    logic                   rst;
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [1:0]             cmd_op;
    logic [CNT_W-1:0]       cmd_count;
    logic [NUM_BP-1:0]      bp_en;
    logic [NUM_BP*XLEN-1:0] bp_addr;
    logic [XLEN-1:0]        pc;
    logic                   core_en;
    logic                   core_rst_n;
    logic                   halted;
    logic [1:0]             halt_cause;
    logic [31:0]            cycle_cnt;

    always #5 clock = ~clock;

    riscv_run_ctrl #(
        .XLEN      (XLEN),
        .CNT_W     (CNT_W),
        .NUM_BP    (NUM_BP),
        .RST_CYCLES(RST_CYCLES)
    ) dut (
        .clock     (clock),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_count (cmd_count),
        .bp_en     (bp_en),
        .bp_addr   (bp_addr),
        .pc        (pc),
        .core_en   (core_en),
        .core_rst_n(core_rst_n),
        .halted    (halted),
        .halt_cause(halt_cause),
        .cycle_cnt (cycle_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Model: cycles of core reset left, running flag, step budget (-1 = free run).
    bit          m_known = 1'b0;
    int          m_rst_left;
    bit          m_running;
    int          m_budget;
    bit          m_skip;
    logic [31:0] m_cnt;
    logic [1:0]  m_cause;
    bit          pc_follow = 1'b1;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] count;
        int          idle;
        bit          exp_halted;
        logic [1:0]  exp_cause;
        logic [31:0] exp_cnt;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_hit();
        for (int i = 0; i < NUM_BP; i++) begin
            if (bp_en[i] && (pc == bp_addr[i*XLEN +: XLEN])) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit model_en();
        bit acc;
        acc = cmd_valid && (m_rst_left == 0);
        if (acc && (cmd_op == 2'd0 || cmd_op == 2'd3)) return 1'b0;
        if (model_hit() && !m_skip) return 1'b0;
        return m_running;
    endfunction

    task automatic model_check();
        bit in_rst;
        if (!m_known) return;
        in_rst = (m_rst_left > 0);
        chk("core_en", 32'(core_en), 32'(model_en()));
        chk("cmd_ready", 32'(cmd_ready), 32'(!in_rst));
        chk("core_rst_n", 32'(core_rst_n), 32'(!in_rst));
        chk("halted", 32'(halted), 32'(!in_rst && !m_running));
        if (!in_rst && !m_running) chk("halt_cause", 32'(halt_cause), 32'(m_cause));
        chk("cycle_cnt", cycle_cnt, m_cnt);
    endtask

    task automatic model_core_reset();
        m_rst_left = RST_CYCLES;
        m_running  = 1'b0;
        m_cnt      = '0;
        m_skip     = 1'b0;
        m_budget   = 0;
    endtask

    task automatic model_update(input bit en);
        bit acc;
        if (!rst) begin
            m_known = 1'b1;
            m_cause = 2'd0;
            model_core_reset();
            return;
        end
        if (!m_known) return;
        acc = cmd_valid && (m_rst_left == 0);
        if (m_rst_left > 0) begin
            m_rst_left--;
            m_cause = 2'd0;
            m_cnt   = '0;
        end else if (!m_running) begin
            if (acc) begin
                if (cmd_op == 2'd1) begin
                    m_running = 1'b1;
                    m_budget  = -1;
                    m_skip    = 1'b1;
                end else if (cmd_op == 2'd2 && cmd_count != 0) begin
                    m_running = 1'b1;
                    m_budget  = int'(cmd_count);
                    m_skip    = 1'b1;
                end else if (cmd_op == 2'd3) begin
                    model_core_reset();
                end
            end
        end else begin
            if (acc && cmd_op == 2'd3) begin
                model_core_reset();
            end else if (model_hit() && !m_skip) begin
                m_running = 1'b0;
                m_cause   = 2'd3;
            end else if (acc && cmd_op == 2'd0) begin
                m_running = 1'b0;
                m_cause   = 2'd2;
            end else if (en) begin
                m_cnt  = m_cnt + 32'd1;
                m_skip = 1'b0;
                if (m_budget > 0) begin
                    m_budget--;
                    if (m_budget == 0) begin
                        m_running = 1'b0;
                        m_cause   = 2'd1;
                    end
                end
            end
        end
    endtask

    // Called at a negedge with inputs settled; returns at the next negedge.
    task automatic tick();
        bit en;
        #1;
        model_check();
        en = m_known ? model_en() : 1'b0;
        model_update(en);
        @(posedge clock);
        @(negedge clock);
        if (pc_follow) begin
            if (!m_known || m_rst_left > 0) pc = '0;
            else if (en) pc = (pc + 32'd4) & 32'h3F;
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [15:0] count);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_count = count;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_halted(input int bound, input string name);
        int n = 0;
        while (halted !== 1'b1 && n < bound) begin
            tick();
            n++;
        end
        chk(name, 32'(halted), 32'd1);
    endtask

    task automatic count_rst_low(input string name);
        int lowc = 0;
        while (core_rst_n === 1'b0 && lowc < 20) begin
            lowc++;
            tick();
        end
        chk(name, 32'(lowc), 32'(RST_CYCLES));
    endtask

    initial begin
        tbl[0] = '{2'd2, 16'd3,  4, 1'b1, 2'd1, 32'd3};
        tbl[1] = '{2'd2, 16'd0,  2, 1'b1, 2'd1, 32'd3};
        tbl[2] = '{2'd0, 16'd0,  2, 1'b1, 2'd1, 32'd3};
        tbl[3] = '{2'd3, 16'd0,  6, 1'b1, 2'd0, 32'd0};
        tbl[4] = '{2'd1, 16'd0, 10, 1'b0, 2'd0, 32'd10};
        tbl[5] = '{2'd0, 16'd0,  1, 1'b1, 2'd2, 32'd10};
        tbl[6] = '{2'd2, 16'd0,  3, 1'b1, 2'd2, 32'd10};
        tbl[7] = '{2'd1, 16'd0,  2, 1'b0, 2'd0, 32'd12};
        tbl[8] = '{2'd2, 16'd5,  3, 1'b0, 2'd0, 32'd16};
        tbl[9] = '{2'd0, 16'd0,  1, 1'b1, 2'd2, 32'd16};

        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_count = '0;
        bp_en     = '0;
        bp_addr   = '0;
        pc        = '0;
        @(negedge clock);

        // Reset release: core reset held for RST_CYCLES, then halted cause RESET.
        tick();
        tick();
        rst = 1'b1;
        count_rst_low("rst_low_cycles");
        chk("rst_halted", 32'(halted), 32'd1);
        chk("rst_cause", 32'(halt_cause), 32'd0);
        chk("rst_cnt", cycle_cnt, 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd1);

        for (int i = 0; i < 10; i++) begin
            send(tbl[i].op, tbl[i].count);
            repeat (tbl[i].idle) tick();
            chk("tbl_halted", 32'(halted), 32'(tbl[i].exp_halted));
            if (tbl[i].exp_halted) chk("tbl_cause", 32'(halt_cause), 32'(tbl[i].exp_cause));
            chk("tbl_cnt", cycle_cnt, tbl[i].exp_cnt);
        end

        // Breakpoint at 0x10, then resume executes it exactly once.
        send(2'd3, 16'd0);
        wait_halted(20, "bp_pre_reset");
        bp_addr[0 +: XLEN]    = 32'h10;
        bp_addr[XLEN +: XLEN] = 32'h1000;
        bp_en                 = 2'b01;
        send(2'd1, 16'd0);
        wait_halted(30, "bp_halt");
        chk("bp_cause", 32'(halt_cause), 32'd3);
        chk("bp_cnt", cycle_cnt, 32'd4);
        send(2'd2, 16'd1);
        wait_halted(10, "bp_step_halt");
        chk("bp_step_cause", 32'(halt_cause), 32'd1);
        chk("bp_step_cnt", cycle_cnt, 32'd5);
        bp_en = '0;

        // RESET_CORE mid-step.
        send(2'd2, 16'd100);
        repeat (5) tick();
        chk("step5_cnt", cycle_cnt, 32'd10);
        send(2'd3, 16'd0);
        count_rst_low("rc_low_cycles");
        chk("rc_halted", 32'(halted), 32'd1);
        chk("rc_cause", 32'(halt_cause), 32'd0);
        chk("rc_cnt", cycle_cnt, 32'd0);

        // Block reset mid-step.
        send(2'd2, 16'd100);
        repeat (5) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        wait_halted(20, "rstmid_halted");
        chk("rstmid_cause", 32'(halt_cause), 32'd0);
        chk("rstmid_cnt", cycle_cnt, 32'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            int r;
            rst       = ($urandom_range(0, 299) != 0);
            cmd_valid = ($urandom_range(0, 3) == 0);
            r         = int'($urandom_range(0, 9));
            cmd_op    = (r < 4) ? 2'd1 : (r < 7) ? 2'd2 : (r < 9) ? 2'd0 : 2'd3;
            cmd_count = CNT_W'($urandom_range(0, 6));
            if (n % 50 == 0) begin
                bp_en = NUM_BP'($urandom_range(0, 3));
                for (int b = 0; b < NUM_BP; b++) begin
                    bp_addr[b*XLEN +: XLEN] = 32'($urandom_range(0, 15)) << 2;
                end
            end
            if ($urandom_range(0, 7) == 0) pc = 32'($urandom_range(0, 15)) << 2;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
